// File: rtl/cmp_debounce.sv
// cmp_debounce
// Debounces the output of a magnitude comparator (AeqB / AgtB) into a stable
// "A above B" level. A change of state needs N consecutive qualifying valid
// samples. EQ counts as "above" once the block is ABOVE, which gives
// hysteresis around the A == B point. The block reports one-cycle rise/fall
// pulses, a saturating count of rise events, and a sticky error flag for the
// impossible comparator code (AeqB & AgtB).
//
// Handshake: in_valid qualifies AeqB/AgtB in the same cycle. There is no
// back-pressure, so every cycle with in_valid=1 is consumed on that rising
// edge. Cycles with in_valid=0 are ignored: all state holds and rise/fall
// read 0.
//
// All outputs are registered. rise/fall appear in the cycle after the edge
// that samples the Nth qualifying sample, together with the change of above.
// The FSM state and run counter are exported on state_dbg / run_dbg so that
// checkers can observe them.
module cmp_debounce #(
   parameter int N  = 4,   // consecutive samples needed to change state (1..255)
   parameter int CW = 8    // width of the rise event counter
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          AeqB,
   input  logic          AgtB,
   input  logic          clr_cnt,
   output logic          above,
   output logic          rise,
   output logic          fall,
   output logic [CW-1:0] evt_cnt,
   output logic          err,
   output logic [1:0]    state_dbg,
   output logic [7:0]    run_dbg
);

   typedef enum logic [1:0] {
      S_BELOW     = 2'd0,
      S_RISE_PEND = 2'd1,
      S_ABOVE     = 2'd2,
      S_FALL_PEND = 2'd3
   } state_e;

   localparam logic [7:0]    N_L     = 8'(N);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   state_e          state_q,   state_d;
   logic [7:0]      run_q,     run_d;
   logic            above_q,   above_d;
   logic            rise_q,    rise_d;
   logic            fall_q,    fall_d;
   logic [CW-1:0]   evt_cnt_q, evt_cnt_d;
   logic            err_q,     err_d;

   logic            s_gt, s_lt, s_bad;
   logic [7:0]      run_inc;
   logic            was_low, now_high, was_high, now_low;

   // Sample classification. EQ is simply "neither GT, LT nor BAD".
   assign s_gt    = AgtB & ~AeqB;
   assign s_lt    = ~AeqB & ~AgtB;
   assign s_bad   = AeqB & AgtB;
   assign run_inc = run_q + 8'd1;

   // Next-state logic: debounce FSM, edge pulses, event counter, error flag.
   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      err_d     = err_q;
      evt_cnt_d = evt_cnt_q;

      if (in_valid) begin
         if (s_bad) begin
            // The illegal code is flagged and otherwise ignored, so a glitchy
            // comparator cannot break or extend a run in progress.
            err_d = 1'b1;
         end else begin
            case (state_q)
               S_BELOW: begin
                  if (s_gt) begin
                     run_d   = 8'd1;
                     state_d = (N_L == 8'd1) ? S_ABOVE : S_RISE_PEND;
                  end else begin
                     run_d = 8'd0;
                  end
               end
               S_RISE_PEND: begin
                  if (s_gt) begin
                     run_d = run_inc;
                     if (run_inc == N_L) state_d = S_ABOVE;
                  end else begin
                     state_d = S_BELOW;
                     run_d   = 8'd0;
                  end
               end
               S_ABOVE: begin
                  // EQ keeps the block above; only a strict LT starts a fall.
                  if (s_lt) begin
                     run_d   = 8'd1;
                     state_d = (N_L == 8'd1) ? S_BELOW : S_FALL_PEND;
                  end else begin
                     run_d = 8'd0;
                  end
               end
               S_FALL_PEND: begin
                  if (s_lt) begin
                     run_d = run_inc;
                     if (run_inc == N_L) state_d = S_BELOW;
                  end else begin
                     state_d = S_ABOVE;
                     run_d   = 8'd0;
                  end
               end
               default: begin
                  state_d = S_BELOW;
                  run_d   = 8'd0;
               end
            endcase
         end
      end

      // Edges are the crossings of the above/below boundary. Aborted pends
      // (RISE_PEND->BELOW, FALL_PEND->ABOVE) do not change the level.
      was_low  = (state_q == S_BELOW) || (state_q == S_RISE_PEND);
      was_high = (state_q == S_ABOVE) || (state_q == S_FALL_PEND);
      now_high = (state_d == S_ABOVE) || (state_d == S_FALL_PEND);
      now_low  = (state_d == S_BELOW) || (state_d == S_RISE_PEND);

      rise_d  = was_low  & now_high;
      fall_d  = was_high & now_low;
      above_d = now_high;

      // Clear beats a same-cycle increment; the rise pulse is unaffected.
      if (clr_cnt) begin
         evt_cnt_d = '0;
      end else if (rise_d && (evt_cnt_q != CNT_MAX)) begin
         evt_cnt_d = evt_cnt_q + CW'(1);
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_BELOW;
         run_q     <= 8'd0;
         above_q   <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         evt_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         above_q   <= above_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         evt_cnt_q <= evt_cnt_d;
         err_q     <= err_d;
      end
   end

   assign above     = above_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign evt_cnt   = evt_cnt_q;
   assign err       = err_q;
   assign state_dbg = state_q;
   assign run_dbg   = run_q;

endmodule

// File: tb/tb_cmp_debounce.sv
// Bench for cmp_debounce. Three instances share one set of inputs:
// u_a (N=4, CW=8), u_b (N=4, CW=2) and u_c (N=1, CW=8). Each scenario task
// pushes the expected output word to exp_q as it drives a sample, then pops
// it and compares after the rising edge.
// Expected word layout: {above, rise, fall, err, state[1:0], evt_cnt[7:0]}.
module tb_cmp_debounce;

   localparam int C_IDLE = 0;
   localparam int C_GT   = 1;
   localparam int C_EQ   = 2;
   localparam int C_LT   = 3;
   localparam int C_BAD  = 4;

   localparam logic [1:0] BL = 2'd0;
   localparam logic [1:0] RP = 2'd1;
   localparam logic [1:0] AB = 2'd2;
   localparam logic [1:0] FP = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic aeqb = 1'b0;
   logic agtb = 1'b0;
   logic clr_cnt = 1'b0;

   logic       a_above, a_rise, a_fall, a_err;
   logic [7:0] a_cnt;
   logic [1:0] a_state;
   logic [7:0] a_run;
   logic       b_above, b_rise, b_fall, b_err;
   logic [1:0] b_cnt;
   logic [1:0] b_state;
   logic [7:0] b_run;
   logic       c_above, c_rise, c_fall, c_err;
   logic [7:0] c_cnt;
   logic [1:0] c_state;
   logic [7:0] c_run;

   logic [13:0] obs_a, obs_b, obs_c;
   logic [13:0] exp_q[$];

   int checks = 0;
   int passed = 0;

   assign obs_a = {a_above, a_rise, a_fall, a_err, a_state, a_cnt};
   assign obs_b = {b_above, b_rise, b_fall, b_err, b_state, 6'd0, b_cnt};
   assign obs_c = {c_above, c_rise, c_fall, c_err, c_state, c_cnt};

   cmp_debounce #(.N(4), .CW(8)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .AeqB(aeqb), .AgtB(agtb),
      .clr_cnt(clr_cnt), .above(a_above), .rise(a_rise), .fall(a_fall),
      .evt_cnt(a_cnt), .err(a_err), .state_dbg(a_state), .run_dbg(a_run));

   cmp_debounce #(.N(4), .CW(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .AeqB(aeqb), .AgtB(agtb),
      .clr_cnt(clr_cnt), .above(b_above), .rise(b_rise), .fall(b_fall),
      .evt_cnt(b_cnt), .err(b_err), .state_dbg(b_state), .run_dbg(b_run));

   cmp_debounce #(.N(1), .CW(8)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .AeqB(aeqb), .AgtB(agtb),
      .clr_cnt(clr_cnt), .above(c_above), .rise(c_rise), .fall(c_fall),
      .evt_cnt(c_cnt), .err(c_err), .state_dbg(c_state), .run_dbg(c_run));

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [13:0] mk(input logic ab, input logic r, input logic f,
                                      input logic e, input logic [1:0] st,
                                      input logic [7:0] c);
      return {ab, r, f, e, st, c};
   endfunction

   // Driver: apply one sample on the falling edge, return just after the rising edge.
   task automatic drive(input int code, input logic clr);
      @(negedge clk);
      clr_cnt = clr;
      case (code)
         C_GT:    begin in_valid = 1'b1; aeqb = 1'b0; agtb = 1'b1; end
         C_EQ:    begin in_valid = 1'b1; aeqb = 1'b1; agtb = 1'b0; end
         C_LT:    begin in_valid = 1'b1; aeqb = 1'b0; agtb = 1'b0; end
         C_BAD:   begin in_valid = 1'b1; aeqb = 1'b1; agtb = 1'b1; end
         default: begin in_valid = 1'b0; aeqb = $urandom_range(0, 1) != 0; agtb = $urandom_range(0, 1) != 0; end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; aeqb = 1'b0; agtb = 1'b0; clr_cnt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (obs_a !== 14'd0) $display("FAIL reset_a: got %h expected %h", obs_a, 14'd0); else passed++;
      checks++; if (obs_b !== 14'd0) $display("FAIL reset_b: got %h expected %h", obs_b, 14'd0); else passed++;
      checks++; if (obs_c !== 14'd0) $display("FAIL reset_c: got %h expected %h", obs_c, 14'd0); else passed++;
      checks++; if (a_run !== 8'd0) $display("FAIL reset_run: got %h expected %h", a_run, 8'd0); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rise();
      logic [13:0] e;
      int codes[5];
      logic [13:0] ex[5];
      codes = '{C_GT, C_GT, C_GT, C_GT, C_EQ};
      ex = '{mk(0,0,0,0,RP,0), mk(0,0,0,0,RP,0), mk(0,0,0,0,RP,0),
             mk(1,1,0,0,AB,1), mk(1,0,0,0,AB,1)};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(ex[i]);
         drive(codes[i], 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) $display("FAIL rise step %0d: got %h expected %h", i, obs_a, e);
         else passed++;
      end
   endtask

   task automatic test_hysteresis();
      logic [13:0] e;
      int codes[20];
      logic [13:0] ex[20];
      codes = '{C_EQ, C_EQ, C_EQ, C_EQ, C_EQ, C_EQ, C_EQ, C_EQ, C_EQ, C_EQ,
                C_LT, C_LT, C_LT, C_LT, C_GT, C_GT, C_IDLE, C_GT, C_GT, C_LT};
      for (int i = 0; i < 10; i++) ex[i] = mk(1,0,0,0,AB,1);
      ex[10] = mk(1,0,0,0,FP,1); ex[11] = mk(1,0,0,0,FP,1); ex[12] = mk(1,0,0,0,FP,1);
      ex[13] = mk(0,0,1,0,BL,1);
      ex[14] = mk(0,0,0,0,RP,1); ex[15] = mk(0,0,0,0,RP,1); ex[16] = mk(0,0,0,0,RP,1);
      ex[17] = mk(0,0,0,0,RP,1); ex[18] = mk(1,1,0,0,AB,2);
      ex[19] = mk(1,0,0,0,FP,2);
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(ex[i]);
         drive(codes[i], 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) $display("FAIL hysteresis step %0d: got %h expected %h", i, obs_a, e);
         else passed++;
      end
      // Aborted fall: back to ABOVE with no pulse.
      exp_q.push_back(mk(1,0,0,0,FP,2)); drive(C_LT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL fall_pend: got %h expected %h", obs_a, e); else passed++;
      exp_q.push_back(mk(1,0,0,0,AB,2)); drive(C_GT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL fall_abort: got %h expected %h", obs_a, e); else passed++;
   endtask

   task automatic test_abort();
      logic [13:0] e;
      int codes[9];
      logic [13:0] ex[9];
      codes = '{C_LT, C_LT, C_LT, C_LT, C_GT, C_GT, C_GT, C_EQ, C_GT};
      ex = '{mk(1,0,0,0,FP,2), mk(1,0,0,0,FP,2), mk(1,0,0,0,FP,2), mk(0,0,1,0,BL,2),
             mk(0,0,0,0,RP,2), mk(0,0,0,0,RP,2), mk(0,0,0,0,RP,2), mk(0,0,0,0,BL,2),
             mk(0,0,0,0,RP,2)};
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(ex[i]);
         drive(codes[i], 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) $display("FAIL abort step %0d: got %h expected %h", i, obs_a, e);
         else passed++;
      end
      checks++; if (a_run !== 8'd1) $display("FAIL abort_run: got %0d expected %0d", a_run, 1); else passed++;
   endtask

   task automatic test_bad_and_reset();
      logic [13:0] e;
      exp_q.push_back(mk(0,0,0,1,RP,2)); drive(C_BAD, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL bad_sample: got %h expected %h", obs_a, e); else passed++;
      checks++; if (a_run !== 8'd1) $display("FAIL bad_run: got %0d expected %0d", a_run, 1); else passed++;
      exp_q.push_back(mk(0,0,0,1,RP,2)); drive(C_GT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL err_sticky: got %h expected %h", obs_a, e); else passed++;
      checks++; if (a_run !== 8'd2) $display("FAIL bad_run2: got %0d expected %0d", a_run, 2); else passed++;
      // Asynchronous reset away from any clock edge.
      #2;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (obs_a !== 14'd0) $display("FAIL async_reset: got %h expected %h", obs_a, 14'd0); else passed++;
      checks++; if (a_run !== 8'd0) $display("FAIL async_reset_run: got %0d expected %0d", a_run, 0); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(mk(0,0,0,0,RP,0)); drive(C_GT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL post_reset: got %h expected %h", obs_a, e); else passed++;
   endtask

   task automatic test_clear();
      logic [13:0] e;
      exp_q.push_back(mk(0,0,0,0,RP,0)); drive(C_GT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL clr_pre1: got %h expected %h", obs_a, e); else passed++;
      exp_q.push_back(mk(0,0,0,0,RP,0)); drive(C_GT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL clr_pre2: got %h expected %h", obs_a, e); else passed++;
      exp_q.push_back(mk(1,1,0,0,AB,1)); drive(C_GT, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL clr_rise: got %h expected %h", obs_a, e); else passed++;
      exp_q.push_back(mk(1,0,0,0,AB,0)); drive(C_IDLE, 1'b1); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL clr_idle: got %h expected %h", obs_a, e); else passed++;
      exp_q.push_back(mk(1,0,0,0,AB,0)); drive(C_IDLE, 1'b0); e = exp_q.pop_front();
      checks++; if (obs_a !== e) $display("FAIL clr_hold: got %h expected %h", obs_a, e); else passed++;
   endtask

   task automatic test_random_gaps();
      logic [13:0] e;
      int gaps;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         gaps = $urandom_range(0, 3);
         for (int g = 0; g < gaps; g++) begin
            exp_q.push_back(mk(0,0,0,0,(k == 0) ? BL : RP,0));
            drive(C_IDLE, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) $display("FAIL gap k%0d g%0d: got %h expected %h", k, g, obs_a, e);
            else passed++;
         end
         exp_q.push_back((k < 3) ? mk(0,0,0,0,RP,0) : mk(1,1,0,0,AB,1));
         drive(C_GT, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) $display("FAIL gap_gt k%0d: got %h expected %h", k, obs_a, e);
         else passed++;
      end
   endtask

   task automatic test_saturate();
      logic [13:0] e;
      logic [7:0]  cnt_prev, cnt_now;
      do_reset();
      cnt_prev = 8'd0;
      for (int r = 1; r <= 6; r++) begin
         for (int g = 0; g < 3; g++) begin
            exp_q.push_back(mk(0,0,0,0,RP,cnt_prev));
            drive(C_GT, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) $display("FAIL sat_pend r%0d g%0d: got %h expected %h", r, g, obs_b, e);
            else passed++;
         end
         cnt_now = (r == 6) ? 8'd0 : ((r < 3) ? 8'(r) : 8'd3);
         exp_q.push_back(mk(1,1,0,0,AB,cnt_now));
         drive(C_GT, (r == 6));
         e = exp_q.pop_front();
         checks++;
         if (obs_b !== e) $display("FAIL sat_rise r%0d: got %h expected %h", r, obs_b, e);
         else passed++;
         if (r < 6) begin
            for (int g = 0; g < 3; g++) drive(C_LT, 1'b0);
            exp_q.push_back(mk(0,0,1,0,BL,cnt_now));
            drive(C_LT, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) $display("FAIL sat_fall r%0d: got %h expected %h", r, obs_b, e);
            else passed++;
         end
         cnt_prev = cnt_now;
      end
   endtask

   task automatic test_n1();
      logic [13:0] e;
      int codes[9];
      logic [13:0] ex[9];
      do_reset();
      codes = '{C_GT, C_GT, C_EQ, C_LT, C_LT, C_EQ, C_GT, C_IDLE, C_LT};
      ex = '{mk(1,1,0,0,AB,1), mk(1,0,0,0,AB,1), mk(1,0,0,0,AB,1), mk(0,0,1,0,BL,1),
             mk(0,0,0,0,BL,1), mk(0,0,0,0,BL,1), mk(1,1,0,0,AB,2), mk(1,0,0,0,AB,2),
             mk(0,0,1,0,BL,2)};
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(ex[i]);
         drive(codes[i], 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs_c !== e) $display("FAIL n1 step %0d: got %h expected %h", i, obs_c, e);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_hysteresis();
      test_abort();
      test_bad_and_reset();
      test_clear();
      test_random_gaps();
      test_saturate();
      test_n1();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
